udp_parser: RTL and testbench

UDP_PARSER -- requirements
Module: udp_parser

---
 rtl/eth_pkg.sv | 15 +
 rtl/udp_parser.sv | 135 +++++++++++++
 tb/tb_udp_parser.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/IP/UDP receive-path types: byte type, UDP header length and
// the UDP parser state encoding.
package eth_pkg;

    typedef logic [7:0] byte_t;

    localparam int UDP_HDR_LEN = 8;

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } udp_state_t;

endpackage

// File: rtl/udp_parser.sv
// Strips the 8-byte UDP header from an IP payload stream, filters on destination
// port and forwards the payload bytes with one cycle of latency.
module udp_parser
    import eth_pkg::*;
#(
    parameter logic [15:0] UDP_PORT = 16'd5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  byte_t       ip_data_in,
    input  logic        ip_byte_valid,
    input  logic        ip_eof,
    input  logic        ip_err,
    output byte_t       udp_data_out,
    output logic        udp_byte_valid,
    output logic        udp_eof,
    output logic        udp_err,
    output logic [15:0] udp_src_port,
    output udp_state_t  dbg_state
);

    // Streams are valid-only: a byte transfers on every rising edge where its
    // valid is high; there is no ready, so this block can never stall the source.

    localparam logic [15:0] HDR_LEN16 = 16'(UDP_HDR_LEN);

    udp_state_t  state;
    logic [2:0]  hdr_cnt;
    logic [15:0] hdr_src;
    logic [15:0] hdr_dest;
    logic [15:0] hdr_len;
    logic [15:0] exp_cnt;
    logic [15:0] pay_cnt;

    logic        hdr_ok;
    logic [16:0] pay_next;

    assign hdr_ok    = (hdr_dest == UDP_PORT) && (hdr_len >= HDR_LEN16);
    assign pay_next  = {1'b0, pay_cnt} + 17'd1;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= HEADER;
            hdr_cnt        <= 3'd0;
            hdr_src        <= 16'h0000;
            hdr_dest       <= 16'h0000;
            hdr_len        <= 16'h0000;
            exp_cnt        <= 16'h0000;
            pay_cnt        <= 16'h0000;
            udp_data_out   <= 8'h00;
            udp_byte_valid <= 1'b0;
            udp_eof        <= 1'b0;
            udp_err        <= 1'b0;
            udp_src_port   <= 16'h0000;
        end else begin
            udp_byte_valid <= 1'b0;
            udp_eof        <= 1'b0;
            udp_err        <= 1'b0;
            if (ip_err) begin
                // Abort wins over everything, including a coincident ip_eof.
                state   <= HEADER;
                hdr_cnt <= 3'd0;
                pay_cnt <= 16'h0000;
                udp_err <= 1'b1;
            end else if (ip_byte_valid) begin
                case (state)
                    HEADER: begin
                        // Checksum bytes (6,7) are consumed but not kept.
                        case (hdr_cnt)
                            3'd0:    hdr_src[15:8]  <= ip_data_in;
                            3'd1:    hdr_src[7:0]   <= ip_data_in;
                            3'd2:    hdr_dest[15:8] <= ip_data_in;
                            3'd3:    hdr_dest[7:0]  <= ip_data_in;
                            3'd4:    hdr_len[15:8]  <= ip_data_in;
                            3'd5:    hdr_len[7:0]   <= ip_data_in;
                            default: ;
                        endcase
                        hdr_cnt <= hdr_cnt + 3'd1;
                        if (hdr_cnt == 3'd7) begin
                            hdr_cnt <= 3'd0;
                            pay_cnt <= 16'h0000;
                            if (hdr_ok) begin
                                exp_cnt      <= hdr_len - HDR_LEN16;
                                udp_src_port <= hdr_src;
                                if (ip_eof) begin
                                    state   <= HEADER;
                                    udp_eof <= (hdr_len == HDR_LEN16);
                                    udp_err <= (hdr_len != HDR_LEN16);
                                end else begin
                                    state <= PAYLOAD;
                                end
                            end else if (ip_eof) begin
                                state   <= HEADER;
                                udp_err <= 1'b1;
                            end else begin
                                state <= DROP;
                            end
                        end else if (ip_eof) begin
                            hdr_cnt <= 3'd0;
                            udp_err <= 1'b1;
                        end
                    end
                    PAYLOAD: begin
                        // Bytes past the UDP length are link-layer padding.
                        if (pay_cnt < exp_cnt) begin
                            udp_byte_valid <= 1'b1;
                            udp_data_out   <= ip_data_in;
                        end
                        if (pay_cnt != 16'hFFFF) begin
                            pay_cnt <= pay_cnt + 16'd1;
                        end
                        if (ip_eof) begin
                            state   <= HEADER;
                            pay_cnt <= 16'h0000;
                            if (pay_next >= {1'b0, exp_cnt}) begin
                                udp_eof <= 1'b1;
                            end else begin
                                udp_err <= 1'b1;
                            end
                        end
                    end
                    DROP: begin
                        if (ip_eof) begin
                            state   <= HEADER;
                            udp_err <= 1'b1;
                        end
                    end
                    default: state <= HEADER;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp_parser.sv
// Bench for udp_parser: table of datagram scenarios plus hand-written abort,
// header-truncation and reset sequences, checked through an expected-output queue.
module tb_udp_parser;
    import eth_pkg::*;

    localparam logic [15:0] P = 16'd5000;
    localparam int W = 28; // {chk_src, src[15:0], valid, data[7:0], eof, err}

    logic        clk;
    logic        rst_n;
    byte_t       ip_data_in;
    logic        ip_byte_valid;
    logic        ip_eof;
    logic        ip_err;
    byte_t       udp_data_out;
    logic        udp_byte_valid;
    logic        udp_eof;
    logic        udp_err;
    logic [15:0] udp_src_port;
    udp_state_t  dbg_state;

    int checks;
    int failures;
    logic [W-1:0] exp_q[$];

    udp_parser #(.UDP_PORT(P)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ip_data_in     (ip_data_in),
        .ip_byte_valid  (ip_byte_valid),
        .ip_eof         (ip_eof),
        .ip_err         (ip_err),
        .udp_data_out   (udp_data_out),
        .udp_byte_valid (udp_byte_valid),
        .udp_eof        (udp_eof),
        .udp_err        (udp_err),
        .udp_src_port   (udp_src_port),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic c, input logic [15:0] s, input logic v,
                                          input byte_t d, input logic e, input logic r);
        return {c, s, v, d, e, r};
    endfunction

    // scoreboard: every non-idle output cycle must match the head of exp_q
    always @(negedge clk) begin
        if (rst_n && (udp_byte_valid || udp_eof || udp_err)) begin
            if (exp_q.size() == 0) begin
                chk("spurious_output", {29'd0, udp_byte_valid, udp_eof, udp_err}, 32'd0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                chk("byte_valid", udp_byte_valid, e[10]);
                if (e[10]) chk("data", udp_data_out, e[9:2]);
                chk("eof", udp_eof, e[1]);
                chk("err", udp_err, e[0]);
                if (e[27]) chk("src_port", udp_src_port, e[26:11]);
            end
        end
    end

    // driver tasks
    task automatic send(input byte_t b, input logic eof, input logic err);
        ip_data_in    = b;
        ip_byte_valid = 1'b1;
        ip_eof        = eof;
        ip_err        = err;
        @(posedge clk); #1;
        ip_byte_valid = 1'b0;
        ip_eof        = 1'b0;
        ip_err        = 1'b0;
        repeat ($urandom_range(0, 1)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_header(input logic [15:0] src, input logic [15:0] dest,
                               input logic [15:0] len, input logic eof_last);
        send(src[15:8], 1'b0, 1'b0);
        send(src[7:0], 1'b0, 1'b0);
        send(dest[15:8], 1'b0, 1'b0);
        send(dest[7:0], 1'b0, 1'b0);
        send(len[15:8], 1'b0, 1'b0);
        send(len[7:0], 1'b0, 1'b0);
        send(byte_t'($urandom_range(0, 255)), 1'b0, 1'b0);
        send(byte_t'($urandom_range(0, 255)), eof_last, 1'b0);
    endtask

    typedef struct {
        logic [15:0] dest;
        logic [15:0] len;
        int          npay;
        int          err_at;   // payload index carrying ip_err, -1 for none
        logic        eof_too;  // ip_eof together with ip_err
        int          exp_fwd;
        logic        exp_eof;
        logic        exp_err;
        logic        acc;      // header accepted, so src port is checked
    } vec_t;

    task automatic run_vec(input vec_t v);
        byte_t       d[$];
        logic [15:0] src;
        logic [W-1:0] t;
        src = 16'($urandom_range(0, 65535));
        for (int i = 0; i < v.npay; i++) d.push_back(byte_t'($urandom_range(0, 255)));
        for (int i = 0; i < v.exp_fwd; i++) exp_q.push_back(pack(v.acc, src, 1'b1, d[i], 1'b0, 1'b0));
        if (v.err_at < 0 && v.npay > 0 && v.exp_fwd == v.npay) begin
            t = exp_q.pop_back();
            t[1:0] = {v.exp_eof, v.exp_err};
            exp_q.push_back(t);
        end else begin
            exp_q.push_back(pack(v.acc, src, 1'b0, 8'h00, v.exp_eof, v.exp_err));
        end
        send_header(src, v.dest, v.len, v.npay == 0);
        for (int i = 0; i < v.npay; i++) begin
            if (i == v.err_at) send(d[i], v.eof_too, 1'b1);
            else               send(d[i], (v.err_at < 0) && (i == v.npay - 1), 1'b0);
        end
    endtask

    vec_t vecs[11];

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        ip_data_in    = 8'h00;
        ip_byte_valid = 1'b0;
        ip_eof        = 1'b0;
        ip_err        = 1'b0;

        vecs[0]  = '{P,       16'd28, 20, -1, 1'b0, 20, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{P + 1,   16'd28, 20, -1, 1'b0,  0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{P,       16'd28, 15, -1, 1'b0, 15, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{P,       16'd10, 18, -1, 1'b0,  2, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{P,       16'd28,  6,  5, 1'b0,  5, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{P,       16'd28, 20, -1, 1'b0, 20, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{P,       16'd8,   0, -1, 1'b0,  0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{P,       16'd8,   4, -1, 1'b0,  0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{P,       16'd4,  10, -1, 1'b0,  0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{P,       16'd9,   1, -1, 1'b0,  1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{P,       16'd28, 20, 19, 1'b1, 19, 1'b0, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", udp_byte_valid, 1'b0);
        chk("rst_eof", udp_eof, 1'b0);
        chk("rst_err", udp_err, 1'b0);
        chk("rst_data", udp_data_out, 8'h00);
        chk("rst_src", udp_src_port, 16'h0000);
        chk("rst_state", dbg_state, HEADER);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // header cut short after 5 bytes
        exp_q.push_back(pack(1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 1'b1));
        send(8'h12, 1'b0, 1'b0);
        send(8'h34, 1'b0, 1'b0);
        send(P[15:8], 1'b0, 1'b0);
        send(P[7:0], 1'b0, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        run_vec(vecs[0]);

        // reset in the middle of a payload: 5 bytes out, then silence
        for (int i = 0; i < 5; i++) exp_q.push_back(pack(1'b1, 16'hBEEF, 1'b1, byte_t'(8'hA0 + i), 1'b0, 1'b0));
        send_header(16'hBEEF, P, 16'd28, 1'b0);
        for (int i = 0; i < 5; i++) send(byte_t'(8'hA0 + i), 1'b0, 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", udp_byte_valid, 1'b0);
        chk("mid_rst_eof", udp_eof, 1'b0);
        chk("mid_rst_err", udp_err, 1'b0);
        chk("mid_rst_data", udp_data_out, 8'h00);
        chk("mid_rst_src", udp_src_port, 16'h0000);
        chk("mid_rst_state", dbg_state, HEADER);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[0]);

        repeat (5) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
